// File: rtl/and_sched_pkg.sv
// Shared types and constants for the masked AND gadget scheduler.
// Holds the FSM state encoding and the 16-bit LFSR definition.
package and_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int LFSR_W = 16;

    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR supplying fresh masking randomness.
// Advances one step per cycle only when step is high.
module lfsr16
    import and_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (step) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/and_gadget_sched.sv
// Round-robin scheduler sharing one masked AND gadget among N requesters.
// Latches operands and fresh randomness per grant, with a completion timeout.
module and_gadget_sched
    import and_sched_pkg::*;
#(
    parameter int          D       = 2,
    parameter int          N       = 4,
    parameter int          TIMEOUT = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         R       = D * (D - 1) / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*D-1:0] req_ina,
    input  logic [N*D-1:0] req_inb,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [D-1:0]   res,
    output logic           err,
    output logic           busy,
    output logic [D-1:0]   and_ina,
    output logic [D-1:0]   and_inb,
    output logic [R-1:0]   and_rin,
    output logic           and_enable,
    input  logic           and_done,
    input  logic [D-1:0]   and_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      done_q, done_d;
    logic              err_q, err_d;
    logic [D-1:0]      res_q, res_d;
    logic [D-1:0]      ina_q, ina_d;
    logic [D-1:0]      inb_q, inb_d;
    logic [R-1:0]      rin_q, rin_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_unused;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    assign lfsr_unused = ^lfsr_state[LFSR_W-1:R];

    // Search upward from the slot after the previous winner
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!win_vld && req[(int'(last_q) + k) % N]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(last_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        res_d     = res_q;
        ina_d     = ina_q;
        inb_d     = inb_q;
        rin_d     = rin_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        lfsr_step = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d          = S_RUN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ina_d     = req_ina[int'(win_idx)*D +: D];
                    inb_d     = req_inb[int'(win_idx)*D +: D];
                    rin_d     = lfsr_state[R-1:0];
                    lfsr_step = 1'b1;
                    last_d    = win_idx;
                    cnt_d     = '0;
                end
            end
            S_RUN: begin
                // Completion takes precedence over a coincident timeout
                if (and_done) begin
                    res_d   = and_out;
                    done_d  = grant_q;
                    state_d = S_DRAIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!and_done) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            ina_q   <= '0;
            inb_q   <= '0;
            rin_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            res_q   <= res_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            rin_q   <= rin_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign res        = res_q;
    assign busy       = (state_q != S_IDLE);
    assign and_ina    = ina_q;
    assign and_inb    = inb_q;
    assign and_rin    = rin_q;
    assign and_enable = (state_q == S_RUN);

endmodule

// File: tb/tb_and_gadget_sched.sv
// Self-checking bench for and_gadget_sched with a behavioural masked AND gadget.
// Expected completions are queued at drive time and matched on each done pulse.
module tb_and_gadget_sched;

    localparam int          D    = 2;
    localparam int          N    = 4;
    localparam int          TO   = 16;
    localparam int          R    = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*D-1:0] req_ina, req_inb;
    logic [N-1:0]   grant, done;
    logic [D-1:0]   res;
    logic           err, busy;
    logic [D-1:0]   and_ina, and_inb;
    logic [R-1:0]   and_rin;
    logic           and_enable;
    logic           and_done;
    logic [D-1:0]   and_out;

    always #5 clk = ~clk;

    and_gadget_sched #(
        .D(D), .N(N), .TIMEOUT(TO), .SEED(SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ina    (req_ina),
        .req_inb    (req_inb),
        .grant      (grant),
        .done       (done),
        .res        (res),
        .err        (err),
        .busy       (busy),
        .and_ina    (and_ina),
        .and_inb    (and_inb),
        .and_rin    (and_rin),
        .and_enable (and_enable),
        .and_done   (and_done),
        .and_out    (and_out)
    );

    // Gadget model: done after g_lat enabled cycles, held g_hold extra
    int   g_lat = 3, g_hold = 0;
    bit   g_never = 1'b0;
    int   mcnt, hcnt;
    logic gdone;

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0; hcnt <= 0; gdone <= 1'b0;
        end else if (and_enable) begin
            mcnt <= mcnt + 1;
            if (!g_never && mcnt == g_lat - 2) gdone <= 1'b1;
        end else if (gdone && hcnt < g_hold) begin
            hcnt <= hcnt + 1;
        end else begin
            mcnt <= 0; hcnt <= 0; gdone <= 1'b0;
        end
    end

    assign and_done = gdone;
    assign and_out  = {and_rin[0] ^ ((^and_ina) & (^and_inb)), and_rin[0]};

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    typedef struct {
        logic [N-1:0] g;
        logic         x;
        logic         e;
        logic [R-1:0] rin;
    } exp_t;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*D-1:0] ina;
        logic [N*D-1:0] inb;
        int             lat;
        int             hold;
        bit             never;
        logic [N-1:0]   g;
    } vec_t;

    exp_t        sbq[$];
    logic [15:0] m_lfsr;

    task automatic push_exp(input logic [N-1:0] g, input bit e,
                            input logic [N*D-1:0] ina,
                            input logic [N*D-1:0] inb);
        exp_t x;
        int   gi;
        gi = 0;
        for (int k = 0; k < N; k++) if (g[k]) gi = k;
        x.g   = g;
        x.e   = e;
        x.x   = e ? 1'b0 : ((^ina[gi*D +: D]) & (^inb[gi*D +: D]));
        x.rin = m_lfsr[R-1:0];
        m_lfsr = lfsr_nx(m_lfsr);
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && err && done == '0) chk("err_alone", 1, 0);
        if (!rst && done != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = sbq.pop_front();
                chk("done_owner", done, e.g);
                chk("err", err, e.e);
                chk("res_xor", ^res, e.x);
                if (e.e) chk("res_zero", res, 0);
                chk("rin", and_rin, e.rin);
            end
        end
    end

    task automatic run_op(input vec_t v);
        int en, dr;
        bit seen;
        g_lat = v.lat; g_hold = v.hold; g_never = v.never;
        push_exp(v.g, v.never, v.ina, v.inb);
        req_ina = v.ina; req_inb = v.inb; req = v.req;
        en = 0; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (and_enable) en++;
            if (done != '0) seen = 1'b1;
        end
        req = '0;
        chk("done_seen", seen, 1);
        chk("en_cycles", en, v.never ? TO : v.lat);
        dr = 1;
        @(negedge clk);
        chk("done_pulse", done, 0);
        while (busy && dr < 50) begin
            dr++;
            @(negedge clk);
        end
        chk("drain_len", dr, v.never ? 1 : 2 + v.hold);
        chk("grant_clr", grant, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        sbq.delete();
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        vec_t v;
        int   cnt;
        rst = 1'b1; req = '0; req_ina = '0; req_inb = '0;
        m_lfsr = SEED;
        tbl[0]  = '{4'b0001, 8'h00, 8'h03, 3,  0, 1'b0, 4'b0001};
        tbl[1]  = '{4'b0010, 8'h04, 8'h08, 3,  3, 1'b0, 4'b0010};
        tbl[2]  = '{4'b0100, 8'h10, 8'h30, 4,  1, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1000, 8'h40, 8'h80, 2,  0, 1'b0, 4'b1000};
        tbl[4]  = '{4'b0001, 8'h01, 8'h01, 3,  0, 1'b1, 4'b0001};
        tbl[5]  = '{4'b0110, 8'hFF, 8'h55, 2,  0, 1'b0, 4'b0010};
        tbl[6]  = '{4'b0101, 8'h96, 8'h69, 3,  1, 1'b0, 4'b0100};
        tbl[7]  = '{4'b1001, 8'h5A, 8'hA5, 2,  0, 1'b0, 4'b1000};
        tbl[8]  = '{4'b1001, 8'h3C, 8'hC3, 5,  2, 1'b0, 4'b0001};
        tbl[9]  = '{4'b1111, 8'h24, 8'h18, 2,  2, 1'b0, 4'b0010};
        tbl[10] = '{4'b0100, 8'h10, 8'h10, 16, 0, 1'b0, 4'b0100};

        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res", res, 0);
        chk("rst_ina", and_ina, 0);
        chk("rst_inb", and_inb, 0);
        chk("rst_rin", and_rin, 0);
        chk("rst_en", and_enable, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 11; i++) run_op(tbl[i]);

        // All four requesters held high: strict rotation from requester 0
        do_reset();
        g_lat = 2; g_hold = 0; g_never = 1'b0;
        req_ina = 8'hB7; req_inb = 8'h6D;
        for (int k = 0; k < 5; k++) push_exp(4'b0001 << (k % 4), 1'b0, req_ina, req_inb);
        req = 4'b1111;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 5; c++) begin
            @(negedge clk);
            if (done != '0) cnt++;
        end
        req = '0;
        chk("rr_done_count", cnt, 5);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        chk("rr_idle", busy, 0);

        // Reset in the second RUN cycle abandons the operation
        g_lat = 5; g_hold = 0; g_never = 1'b0;
        req_ina = 8'h33; req_inb = 8'h0F;
        req = 4'b0100;
        cnt = 0;
        for (int c = 0; c < 20 && grant == '0; c++) @(negedge clk);
        chk("mid_grant", grant, 4'b0100);
        @(negedge clk);
        chk("mid_en", and_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run_en", and_enable, 0);
        chk("rst_run_grant", grant, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_done", done, 0);
        rst = 1'b0;
        m_lfsr = SEED;
        v = '{4'b0101, 8'h1B, 8'h2E, 3, 0, 1'b0, 4'b0001};
        run_op(v);

        for (int i = 0; i < 1000; i++) begin
            int r;
            r = $urandom_range(0, N - 1);
            v.req   = 4'b0001 << r;
            v.g     = v.req;
            v.ina   = 8'($urandom);
            v.inb   = 8'($urandom);
            v.lat   = $urandom_range(2, 6);
            v.hold  = $urandom_range(0, 2);
            v.never = ($urandom_range(0, 19) == 0);
            run_op(v);
        end

        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/and_gadget_sched.md
AND_GADGET_SCHED -- requirements
Module: and_gadget_sched

Interface
REQ-001 Parameter D, default 2, number of shares per masked operand.
REQ-002 Parameter N, default 4, number of requesters sharing one masked AND gadget.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles to wait for gadget completion.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-005 Derived constant R = D*(D-1)/2, the number of fresh random bits per evaluation; D SHALL satisfy 2 <= D <= 6.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req  in  N  per-requester request, held high until its done pulse.
REQ-009 req_ina, req_inb  in  N*D  operand shares; requester i occupies bits [i*D +: D].
REQ-010 grant  out  N  one-hot owner of the gadget, held for the whole service.
REQ-011 done  out  N  one-cycle completion pulse to the owner.
REQ-012 res  out  D  result shares, valid in the done cycle and held until the next done.
REQ-013 err  out  1  one-cycle pulse, coincident with done, on timeout.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 and_ina, and_inb  out  D  operand shares driven to the gadget.
REQ-016 and_rin  out  R  randomness driven to the gadget.
REQ-017 and_enable  out  1  gadget enable (level).
REQ-018 and_done, and_out  in  1 / D  gadget completion level and output shares.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-020 IDLE: when req != 0, the block SHALL select the winner round-robin, searching upward from (last winner + 1) mod N, and move to RUN on the next edge.
REQ-021 On grant, the block SHALL latch the winner's shares into and_ina/and_inb, load and_rin from LFSR bits [R-1:0], advance the LFSR one step, and set grant.
REQ-022 and_enable SHALL be high in every RUN cycle and low in IDLE and DRAIN.
REQ-023 Operands and and_rin SHALL stay stable from grant until DRAIN is left.
REQ-024 RUN: on the first cycle with and_done=1, the block SHALL capture and_out into res, pulse done[winner] on the next cycle, and enter DRAIN.
REQ-025 RUN: a cycle counter SHALL start at 0 on RUN entry; when it reaches TIMEOUT-1 with and_done=0, the block SHALL set res to 0, pulse done[winner] and err, and enter DRAIN.
REQ-026 If and_done and the timeout coincide, completion SHALL win and err SHALL stay low.
REQ-027 DRAIN: the block SHALL wait for and_done=0, then clear grant and return to IDLE; the minimum length of DRAIN is 1 cycle.
REQ-028 Requests arriving during service SHALL be held pending, and no request SHALL ever be dropped.
REQ-029 A requester that keeps req high after done SHALL be served again only after every other pending requester has been served.
REQ-030 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, and SHALL advance only on grants.

Reset
REQ-031 While rst=1, the block SHALL set FSM=IDLE, LFSR=SEED, last winner=N-1 (so requester 0 has first priority), and all outputs to 0 (grant, done, err, busy, res, and_ina, and_inb, and_rin, and_enable).
REQ-032 A reset during RUN or DRAIN SHALL abandon the operation with no done pulse, and and_enable SHALL be low in the first cycle after reset.

Structure
REQ-033 The state encoding and the LFSR polynomial/width constants SHALL live in a shared package, and_sched_pkg.
REQ-034 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst, step and state.

Verification
REQ-035 D=2, req=0001, ina=00, inb=11, gadget model raises and_done 3 cycles after enable -> and_enable high for 3 cycles, done=0001 one cycle later, res equals the model output, and XOR of res equals AND of the unmasked values (0).
REQ-036 req=1111 held continuously -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-037 Gadget never asserts and_done -> done and err pulse together 16 cycles after enable rises, with res=00.
REQ-038 rst asserted in the 2nd RUN cycle -> and_enable, grant and busy are 0 on the next cycle, there is no done pulse, and the next grant goes to requester 0 with and_rin = SEED[R-1:0].
REQ-039 Two consecutive grants -> and_rin equals successive LFSR states (low bits), and and_done held high for 3 extra cycles extends DRAIN accordingly.
REQ-040 Random operands across all requesters for 1000 operations -> XOR of res equals the bitwise AND of the unmasked operands for every operation.
